// File: rtl/testvec_capture_ctrl_if.sv
// AXI-Stream link carrying captured test-vector frames toward the S2MM DMA channel.
interface testvec_capture_ctrl_if #(
    parameter int DATA_W = 64
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tvalid;
    logic                tready;
    logic                tlast;

    modport master (
        output tdata,
        output tkeep,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/testvec_capture_ctrl.sv
// Capture controller: keeps a pre-trigger history of the test-vector stream, waits for a
// masked pattern match, then emits one framed AXI-Stream packet ending with tlast.
module testvec_capture_ctrl #(
    parameter int  DATA_W = 64,
    parameter int  DEPTH  = 32,
    localparam int PW     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     vec_in,
    input  logic                  cfg_arm,
    input  logic                  cfg_abort,
    input  logic                  cfg_force_trig,
    input  logic [DATA_W-1:0]     cfg_trig_mask,
    input  logic [DATA_W-1:0]     cfg_trig_value,
    input  logic [PW-1:0]         cfg_pre_len,
    input  logic [15:0]           cfg_post_len,
    testvec_capture_ctrl_if.master m,
    output logic [2:0]            sts_state,
    output logic                  sts_done,
    output logic                  sts_overflow,
    output logic [15:0]           sts_drop_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_POST  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e              state_q;
    logic [DATA_W-1:0]   mask_q;
    logic [DATA_W-1:0]   value_q;
    logic [PW-1:0]       pre_len_q;
    logic [15:0]         post_len_q;
    logic [15:0]         post_rem_q;
    logic                done_q;
    logic                ovf_q;
    logic [15:0]         drop_q;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW:0]         count_q, count_d;

    logic                trig_hit;
    logic                fifo_full;
    logic                tvalid;
    logic                pop;
    logic                push;
    logic                discard;
    logic                drop;
    logic                rd_adv;

    assign trig_hit  = (((vec_in ^ value_q) & mask_q) == '0) || cfg_force_trig;
    assign fifo_full = (count_q == (PW+1)'(DEPTH));
    assign tvalid    = ((state_q == S_POST) || (state_q == S_DRAIN)) && (count_q != '0);
    assign pop       = tvalid && m.tready && !cfg_abort;

    always_comb begin
        push    = 1'b0;
        discard = 1'b0;
        drop    = 1'b0;
        if (!cfg_abort) begin
            case (state_q)
                S_ARMED: begin
                    push = 1'b1;
                    // Keep occupancy at pre_len by retiring the oldest sample; the
                    // trigger sample itself is always kept on top of the history.
                    if (!trig_hit && (count_q >= (PW+1)'(pre_len_q))) begin
                        discard = 1'b1;
                    end
                end
                S_POST: begin
                    if (fifo_full && !pop) begin
                        drop = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_adv   = pop || discard;
    assign wr_ptr_d = wr_ptr_q + PW'(push);
    assign rd_ptr_d = rd_ptr_q + PW'(rd_adv);
    assign count_d  = count_q + (PW+1)'(push) - (PW+1)'(rd_adv);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= vec_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            post_rem_q <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            drop_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (cfg_abort && (state_q != S_IDLE)) begin
                state_q  <= S_IDLE;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (cfg_arm) begin
                            mask_q     <= cfg_trig_mask;
                            value_q    <= cfg_trig_value;
                            pre_len_q  <= cfg_pre_len;
                            post_len_q <= cfg_post_len;
                            wr_ptr_q   <= '0;
                            rd_ptr_q   <= '0;
                            count_q    <= '0;
                            done_q     <= 1'b0;
                            ovf_q      <= 1'b0;
                            drop_q     <= '0;
                            state_q    <= S_ARMED;
                        end else if (state_q == S_DONE) begin
                            state_q <= S_IDLE;
                        end
                    end
                    S_ARMED: begin
                        if (trig_hit) begin
                            post_rem_q <= post_len_q;
                            state_q    <= (post_len_q == '0) ? S_DRAIN : S_POST;
                        end
                    end
                    S_POST: begin
                        post_rem_q <= post_rem_q - 16'd1;
                        if (drop) begin
                            ovf_q <= 1'b1;
                            if (drop_q != 16'hFFFF) begin
                                drop_q <= drop_q + 16'd1;
                            end
                        end
                        if (post_rem_q == 16'd1) begin
                            state_q <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        // count 0 here is unreachable in normal flow; treat it as frame end.
                        if ((pop && (count_q == (PW+1)'(1))) || (count_q == '0)) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign m.tdata      = tvalid ? mem_q[rd_ptr_q] : '0;
    assign m.tkeep      = '1;
    assign m.tvalid     = tvalid;
    assign m.tlast      = tvalid && (state_q == S_DRAIN) && (count_q == (PW+1)'(1));
    assign sts_state    = state_q;
    assign sts_done     = done_q;
    assign sts_overflow = ovf_q;
    assign sts_drop_cnt = drop_q;

endmodule

// File: tb/tb_testvec_capture_ctrl.sv
// Directed bench for testvec_capture_ctrl: frames, masks, backpressure, abort and re-arm.
module tb_testvec_capture_ctrl;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 32;
    localparam int PW     = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] vec_in;
    logic              cfg_arm, cfg_abort, cfg_force_trig;
    logic [DATA_W-1:0] cfg_trig_mask, cfg_trig_value;
    logic [PW-1:0]     cfg_pre_len;
    logic [15:0]       cfg_post_len;
    logic [2:0]        sts_state;
    logic              sts_done, sts_overflow;
    logic [15:0]       sts_drop_cnt;

    testvec_capture_ctrl_if #(.DATA_W(DATA_W)) axis ();

    testvec_capture_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .vec_in         (vec_in),
        .cfg_arm        (cfg_arm),
        .cfg_abort      (cfg_abort),
        .cfg_force_trig (cfg_force_trig),
        .cfg_trig_mask  (cfg_trig_mask),
        .cfg_trig_value (cfg_trig_value),
        .cfg_pre_len    (cfg_pre_len),
        .cfg_post_len   (cfg_post_len),
        .m              (axis),
        .sts_state      (sts_state),
        .sts_done       (sts_done),
        .sts_overflow   (sts_overflow),
        .sts_drop_cnt   (sts_drop_cnt)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          stab_viol = 0;
    logic [63:0] got_d[$];
    bit          got_l[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        vec_in         = vec_in + 1;
        cfg_arm        = 1'b0;
        cfg_abort      = 1'b0;
        cfg_force_trig = 1'b0;
    endtask

    task automatic arm(input logic [63:0] v0, input logic [63:0] mask, input logic [63:0] val,
                       input int pre, input int post);
        vec_in         = v0;
        cfg_trig_mask  = mask;
        cfg_trig_value = val;
        cfg_pre_len    = PW'(pre);
        cfg_post_len   = 16'(post);
        cfg_arm        = 1'b1;
        tick();
    endtask

    // mode 0: tready low, 1: tready high, 2: random tready
    task automatic run(input string tag, input int mode, input int stop_state, input int budget);
        logic        prev_stall = 1'b0;
        logic [63:0] prev_d = '0;
        logic        prev_l = 1'b0;
        got_d.delete();
        got_l.delete();
        for (int k = 0; k < budget; k++) begin
            if (sts_state == 3'(stop_state)) break;
            axis.tready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'(mode);
            if (prev_stall && ((axis.tdata !== prev_d) || (axis.tlast !== prev_l))) stab_viol++;
            if (axis.tvalid && axis.tready) begin
                got_d.push_back(axis.tdata);
                got_l.push_back(axis.tlast);
            end
            prev_stall = axis.tvalid && !axis.tready;
            prev_d     = axis.tdata;
            prev_l     = axis.tlast;
            tick();
        end
        chk({tag, "_reach_state"}, 64'(sts_state), 64'(stop_state));
    endtask

    task automatic chk_frame(input string tag, input logic [63:0] first, input int n);
        chk({tag, "_len"}, 64'(got_d.size()), 64'(n));
        for (int i = 0; i < got_d.size() && i < n; i++) begin
            chk($sformatf("%s_data%0d", tag, i), got_d[i], first + 64'(i));
            chk($sformatf("%s_last%0d", tag, i), 64'(got_l[i]), 64'(i == n - 1));
        end
    endtask

    initial begin
        rst            = 1'b1;
        vec_in         = '0;
        cfg_arm        = 1'b0;
        cfg_abort      = 1'b0;
        cfg_force_trig = 1'b0;
        cfg_trig_mask  = '0;
        cfg_trig_value = '0;
        cfg_pre_len    = '0;
        cfg_post_len   = '0;
        axis.tready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_state", 64'(sts_state), 64'd0);
        chk("rst_tvalid", 64'(axis.tvalid), 64'd0);
        chk("rst_tlast", 64'(axis.tlast), 64'd0);
        chk("rst_tdata", axis.tdata, 64'd0);
        chk("rst_tkeep", 64'(axis.tkeep), 64'hFF);
        chk("rst_done", 64'(sts_done), 64'd0);
        chk("rst_ovf", 64'(sts_overflow), 64'd0);
        chk("rst_drop", 64'(sts_drop_cnt), 64'd0);

        // Basic frame: history 0x0C..0x0F, trigger 0x10, post 0x11..0x13
        arm(64'h0, '1, 64'h10, 4, 3);
        chk("basic_armed", 64'(sts_state), 64'd1);
        run("basic", 1, 4, 200);
        chk_frame("basic", 64'h0C, 8);
        chk("basic_done", 64'(sts_done), 64'd1);
        chk("basic_drop", 64'(sts_drop_cnt), 64'd0);
        tick();
        chk("done_to_idle", 64'(sts_state), 64'd0);
        chk("done_held", 64'(sts_done), 64'd1);

        // Mask 0: the first ARMED sample (0x41) triggers and is the whole frame
        arm(64'h40, 64'h0, 64'h0, 8, 0);
        run("mask0", 1, 4, 50);
        chk_frame("mask0", 64'h41, 1);

        // Arm while ARMED must not relatch value 0x305 / post_len 0
        arm(64'h300, '1, 64'h310, 2, 2);
        cfg_trig_value = 64'h305;
        cfg_post_len   = 16'd0;
        cfg_pre_len    = PW'(7);
        cfg_arm        = 1'b1;
        tick();
        chk("ign_arm_state", 64'(sts_state), 64'd1);
        run("ignarm", 1, 4, 100);
        chk_frame("ignarm", 64'h30E, 5);

        // Backpressure: 5 held at trigger, 27 more fit, 73 of 100 post samples dropped
        arm(64'h100, '1, 64'h108, 4, 100);
        run("bp_fill", 0, 3, 300);
        chk("bp_ovf", 64'(sts_overflow), 64'd1);
        chk("bp_drop", 64'(sts_drop_cnt), 64'd73);
        run("bp_drain", 1, 4, 100);
        chk_frame("bp", 64'h104, 32);

        // Re-arm straight from DONE clears status, then random tready frame
        arm(64'h200, '1, 64'h208, 5, 20);
        chk("rearm_state", 64'(sts_state), 64'd1);
        chk("rearm_done", 64'(sts_done), 64'd0);
        chk("rearm_ovf", 64'(sts_overflow), 64'd0);
        chk("rearm_drop", 64'(sts_drop_cnt), 64'd0);
        run("rnd", 2, 4, 500);
        chk_frame("rnd", 64'h203, 26);
        chk("rnd_drop", 64'(sts_drop_cnt), 64'd0);

        // Abort mid-POST, then a clean frame must contain nothing stale
        arm(64'h500, '1, 64'h504, 3, 10);
        run("ab_trig", 0, 2, 50);
        tick();
        tick();
        chk("ab_post_valid", 64'(axis.tvalid), 64'd1);
        cfg_abort = 1'b1;
        tick();
        chk("ab_state", 64'(sts_state), 64'd0);
        chk("ab_tvalid", 64'(axis.tvalid), 64'd0);
        chk("ab_tlast", 64'(axis.tlast), 64'd0);
        arm(64'h600, '1, 64'h606, 3, 2);
        run("ab_clean", 1, 4, 100);
        chk_frame("ab_clean", 64'h603, 6);

        chk("axis_stable", 64'(stab_viol), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/testvec_capture_ctrl.md
# testvec_capture_ctrl

Logic-analyzer style capture controller that sequences the 64-bit DUT test-vector stream into the testvec S2MM DMA channel. It keeps a programmable pre-trigger history and waits for a masked pattern match. It then emits exactly one framed AXI-Stream packet (pre-trigger + trigger + post-trigger samples) with `tlast` on the final word. It sits between the DUT `testvec` output and the `testvec_s2mm_*` interface of the base block design, replacing the free-running constant-valid hookup.

## Interface
Parameters:
- `DATA_W`, 64, sample/stream width.
- `DEPTH`, 32, FIFO depth in samples; power of 2, ≥4.
- `PW`, `$clog2(DEPTH)`, width of `cfg_pre_len` (localparam).

Ports:
- `clk`  in  1  capture clock (tb_clk domain).
- `rst`  in  1  synchronous, active-high reset.
- `vec_in`  in  DATA_W  test vector, sampled every cycle.
- `cfg_arm`  in  1  single-cycle start pulse; latches all `cfg_*`.
- `cfg_abort`  in  1  single-cycle abort pulse.
- `cfg_force_trig`  in  1  forces trigger while ARMED.
- `cfg_trig_mask`  in  DATA_W  bit set = compare bit.
- `cfg_trig_value`  in  DATA_W  compare value.
- `cfg_pre_len`  in  PW  pre-trigger samples kept (0..DEPTH-1).
- `cfg_post_len`  in  16  samples captured after the trigger sample.
- `m_tdata`  out  DATA_W  stream data.
- `m_tkeep`  out  DATA_W/8  constant all-ones.
- `m_tvalid`  out  1  stream valid.
- `m_tready`  in  1  stream ready.
- `m_tlast`  out  1  last word of frame.
- `sts_state`  out  3  current state encoding.
- `sts_done`  out  1  frame fully delivered.
- `sts_overflow`  out  1  sticky: ≥1 post sample dropped.
- `sts_drop_cnt`  out  16  dropped samples, saturating.

## Operation
States are IDLE=0, ARMED=1, POST=2, DRAIN=3, DONE=4.
- IDLE: FIFO empty, no pushes.
  - `cfg_arm` latches config, clears FIFO, overflow and drop count, and sets `sts_done=0`.
  - Next state: ARMED.
- ARMED: push `vec_in` every cycle.
  - If occupancy would exceed latched `pre_len`, discard the oldest entry in the same cycle, so occupancy ≤ `pre_len`.
  - No stream output (`m_tvalid=0`).
  - Trigger condition: `((vec_in ^ value) & mask) == 0`, or `cfg_force_trig`. Mask 0 triggers on the first ARMED cycle.
  - On trigger, that sample is pushed (no discard that cycle), `post_rem` is loaded with `post_len`, and the next state is POST. If `post_len==0`, go directly to DRAIN.
- POST: push `vec_in` each cycle and decrement `post_rem`. Stream pops run concurrently.
  - If FIFO full and no pop this cycle, the sample is dropped: set `sts_overflow`, increment `sts_drop_cnt` (saturate 0xFFFF). `post_rem` still decrements.
  - On the cycle `post_rem` reaches 0 after its final decrement, go to DRAIN.
- DRAIN: no pushes; pop until empty.
  - `m_tlast = m_tvalid & (count==1)`.
  - Handshake on the tlast word → DONE.
- DONE: `sts_done=1`, FIFO empty.
  - `cfg_arm` re-arms as from IDLE.
  - One cycle later the state returns to IDLE if no arm arrives; `sts_done` holds until the next arm.
- Stream rules:
  - `m_tvalid = (state∈{POST,DRAIN}) & count!=0`.
  - `m_tdata` is the FIFO head (asynchronous-read memory).
  - Pop on `m_tvalid & m_tready`.
  - Push and pop in the same cycle leave count unchanged.
- Frame length delivered = occupancy at trigger + 1 + `post_len` − drops.
- `cfg_arm` outside IDLE/DONE is ignored.
- `cfg_abort` in any state → IDLE next cycle, FIFO flushed, `m_tvalid` drops; any partial frame is truncated without `tlast`. Abort has priority over arm.
- `cfg_abort` in IDLE is a no-op.

## Timing
- Reset values: all outputs 0 except `m_tkeep` (all-ones) and `sts_state` (IDLE=0); FIFO pointers and count 0; `sts_done=0`.
- Latency:
  - Arm pulse at cycle N → ARMED at N+1; first sample pushed at N+1.
  - A sample pushed at cycle T is visible on `m_tdata` at T+1 at the earliest.
- Trigger compare is registered-free: it is evaluated on the same-cycle `vec_in`.
- `m_tdata`/`m_tlast` stay stable while `m_tvalid & !m_tready`, except on abort.
- Full throughput: with `m_tready` held high, no drops occur for any `post_len`.

## Test plan
- **Basic frame:** `pre_len`=4, mask=all-ones, value=0x10, `vec_in`=counter 0,1,2…, `post_len`=3, `tready`=1.
  - Frame is 0x0C..0x13 (8 words); `tlast` only on 0x13; DONE reached; `drop_cnt`=0.
- **Mask 0:** trigger on the first ARMED sample; `pre_len`=8, `post_len`=0.
  - Single-word frame carrying the arm+1 sample with `tlast`=1.
- **Backpressure:** `DEPTH`=32, `post_len`=100, `tready`=0 throughout POST.
  - FIFO fills; `sts_overflow`=1; `drop_cnt` = 101 − 32 + occupancy-at-trigger adjustment, checked against the model.
  - After `tready`=1 exactly 32 words are delivered, the last with `tlast`.
- **Random tready (50%):** `post_len`=20, `pre_len`=5.
  - Delivered words match the scoreboard sequence; no AXIS stability violation; `tlast` on word 26.
- **Abort mid-POST:** `cfg_abort` pulsed mid-POST.
  - Next cycle `m_tvalid`=0, state IDLE, count 0.
  - A subsequent arm produces a clean full frame.
- **Re-arm and ignored arm:** `cfg_arm` during ARMED is ignored (config unchanged); re-arm in DONE clears `sts_done`, `sts_overflow` and `drop_cnt`.
